// File: rtl/error_detector.sv
// Lockstep retirement comparator: flags A/B divergence or excessive retirement skew, then blocks until recovery.
// Define ERROR_DETECTOR_COUNT_EN to build the saturating mismatch counter; otherwise mismatch_count_o is tied to zero.
module error_detector #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_a_i,
    input  logic                  valid_b_i,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    input  logic [DATA_WIDTH-1:0] pc_a_i,
    input  logic [DATA_WIDTH-1:0] pc_b_i,
    input  logic                  recovery_done_i,
    input  logic                  clear_i,
    output logic                  error_o,
    output logic                  busy_o,
    output logic                  sticky_error_o,
    output logic [CNT_WIDTH-1:0]  mismatch_count_o
);
    localparam int SKEW_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FLAG, BLOCKED} state_t;

    state_t                state_q, state_d;
    logic                  valid_a_q, valid_b_q, we_a_q, we_b_q;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q, pc_a_q, pc_b_q;
    logic [SKEW_W-1:0]     skew_q, skew_d;
    logic                  error_q, error_d, busy_q, busy_d;
    logic                  sticky_q, sticky_d;
    logic                  both_valid, one_valid, mismatch, timeout, enter_flag;

    always_comb begin
        both_valid = valid_a_q & valid_b_q;
        one_valid  = valid_a_q ^ valid_b_q;
        mismatch   = both_valid &&
                     ((pc_a_q != pc_b_q) || (we_a_q != we_b_q) ||
                      (we_a_q && we_b_q && (waddr_a_q != waddr_b_q)) ||
                      (we_a_q && we_b_q && (waddr_a_q != '0) && (wdata_a_q != wdata_b_q)));

        // Skew is only tracked while comparing; a flagged episode restarts it from zero.
        skew_d = skew_q;
        if (state_q != IDLE || both_valid)
            skew_d = '0;
        else if (one_valid && skew_q != SKEW_W'(TIMEOUT))
            skew_d = skew_q + 1'b1;
        timeout = (state_q == IDLE) && (skew_d == SKEW_W'(TIMEOUT));

        enter_flag = (state_q == IDLE) && (mismatch || timeout);

        state_d = state_q;
        case (state_q)
            IDLE:    if (enter_flag) state_d = FLAG;
            FLAG:    state_d = BLOCKED;
            BLOCKED: if (recovery_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        error_d  = (state_d == FLAG);
        busy_d   = (state_d != IDLE);
        sticky_d = enter_flag ? 1'b1 : (clear_i ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            waddr_b_q <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
            pc_a_q    <= '0;
            pc_b_q    <= '0;
            skew_q    <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_a_q <= valid_a_i;
            valid_b_q <= valid_b_i;
            we_a_q    <= we_a_i;
            we_b_q    <= we_b_i;
            waddr_a_q <= waddr_a_i;
            waddr_b_q <= waddr_b_i;
            wdata_a_q <= wdata_a_i;
            wdata_b_q <= wdata_b_i;
            pc_a_q    <= pc_a_i;
            pc_b_q    <= pc_b_i;
            skew_q    <= skew_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            sticky_q  <= sticky_d;
        end
    end

`ifdef ERROR_DETECTOR_COUNT_EN
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // A flag in the same cycle as clear_i survives the clear as a count of one.
    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = enter_flag ? CNT_WIDTH'(1) : '0;
        else if (enter_flag && count_q != '1)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign mismatch_count_o = count_q;
`else
    assign mismatch_count_o = '0;
`endif

    assign error_o        = error_q;
    assign busy_o         = busy_q;
    assign sticky_error_o = sticky_q;
endmodule

// File: doc/error_detector.md
ERROR_DETECTOR -- requirements
Module: error_detector

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register address width of each core write port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: write-data and PC width.
REQ-003 SHALL have parameter TIMEOUT, default 4: maximum consecutive one-sided-valid cycles tolerated.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: mismatch counter width.
REQ-005 SHALL have ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_a_i / valid_b_i  in  1  core A/B retired an instruction this cycle.
- we_a_i / we_b_i  in  1  core A/B register write enable.
- waddr_a_i / waddr_b_i  in  ADDR_WIDTH  core A/B write address.
- wdata_a_i / wdata_b_i  in  DATA_WIDTH  core A/B write data.
- pc_a_i / pc_b_i  in  DATA_WIDTH  core A/B retired PC.
- recovery_done_i  in  1  recovery controller asserted resume.
- clear_i  in  1  synchronous clear of sticky_error_o and the counter.
- error_o  out  1  one-cycle error pulse to the recovery controller.
- busy_o  out  1  high while waiting for recovery.
- sticky_error_o  out  1  latched "an error has occurred".
- mismatch_count_o  out  CNT_WIDTH  number of errors flagged.

Function
REQ-006 SHALL register all A/B inputs into a stage-1 register on every clock edge.
REQ-007 SHALL compute a mismatch from stage 1 only when both valids are 1: PCs differ, or we differ, or both we are 1 with waddr differing, or both we are 1 with nonzero waddr and wdata differing.
REQ-008 SHALL ignore wdata when both cores write address 0.
REQ-009 SHALL keep a skew counter on stage 1:
- +1 when exactly one valid is 1.
- Cleared when both valids are 1.
- Held when neither valid is 1.
REQ-010 SHALL raise a timeout when the skew counter reaches TIMEOUT.
REQ-011 SHALL implement FSM states IDLE, FLAG and BLOCKED.
REQ-012 SHALL use these transitions:
- IDLE->FLAG on mismatch or timeout.
- FLAG->BLOCKED unconditionally.
- BLOCKED->IDLE when recovery_done_i=1.
REQ-013 SHALL drive error_o=1 only in FLAG, so it is exactly one cycle wide.
REQ-014 SHALL have 2-edge latency: mismatching inputs sampled at edge k give error_o high for the cycle after edge k+1.
REQ-015 SHALL drive busy_o=1 in FLAG and BLOCKED.
REQ-016 SHALL discard mismatch and timeout in FLAG and BLOCKED, and hold the skew counter cleared there.
REQ-017 SHALL produce one FLAG and one count increment when mismatch and timeout occur in the same cycle.
REQ-018 SHALL ignore recovery_done_i in IDLE and FLAG.
REQ-019 SHALL set sticky_error_o on entry to FLAG and clear it only on rst_i or clear_i.
REQ-020 SHALL give a set priority over clear_i when both occur in the same cycle.
REQ-021 SHALL let clear_i leave the FSM state unaffected.

Reset
REQ-022 SHALL, on rst_i=1 and independent of clk_i, force:
- FSM to IDLE.
- Stage-1 valids to 0 and the skew counter to 0.
- error_o=0, busy_o=0, sticky_error_o=0, mismatch_count_o=0.
REQ-023 SHALL, when rst_i is asserted mid-BLOCKED, discard the pending recovery and not re-flag it after reset.
REQ-024 SHALL resume comparison on the first edge after rst_i deasserts, with stage 1 empty (valids 0).

Configuration
REQ-025 SHALL compile a saturating counter when macro ERROR_DETECTOR_COUNT_EN is defined:
- mismatch_count_o increments by 1 on each entry to FLAG.
- It saturates at 2^CNT_WIDTH-1.
- It clears on rst_i or clear_i.
REQ-026 SHALL tie mismatch_count_o to 0 and omit the counter logic when ERROR_DETECTOR_COUNT_EN is not defined.

Verification
REQ-027 SHALL cover matched stream: 100 identical retirements -> error_o never 1, sticky_error_o=0.
REQ-028 SHALL cover data mismatch:
- Stimulus: waddr=5, wdata_a=0x12, wdata_b=0x13 at edge k.
- Response: error_o high one cycle after edge k+1, busy_o=1, count=1.
- Then: recovery_done_i -> busy_o=0 next cycle.
REQ-029 SHALL cover x0 write: both write waddr=0 with wdata 0x1 vs 0x2 -> no error.
REQ-030 SHALL cover skew:
- valid_a=1, valid_b=0 for 4 cycles (TIMEOUT=4) -> one error_o pulse.
- Same for 3 cycles followed by both valid -> no error.
REQ-031 SHALL cover blocked window: PC mismatch injected while BLOCKED -> no second pulse, count unchanged.
REQ-032 SHALL cover saturation/clear:
- Stimulus: CNT_WIDTH=2, 5 errors with recovery between each.
- Response: count=3.
- Then: clear_i -> count=0, sticky_error_o=0.
